// File: rtl/pipelinedefs_pkg.sv
// Shared pipeline definitions: MEM/WB register field layout, writeback
// source encodings and load size encodings.
package pipelinedefs;

  // Writeback result source selection
  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_LOAD = 2'b01,
    WB_SEL_PC4  = 2'b10,
    WB_SEL_ALU2 = 2'b11
  } wbsel_e;

  // Load access size; both 10 and 11 mean a byte access
  typedef enum logic [1:0] {
    LD_WORD  = 2'b00,
    LD_HALF  = 2'b01,
    LD_BYTE  = 2'b10,
    LD_BYTE2 = 2'b11
  } ldsize_e;

  // MEM/WB register field positions (LSB of each field, packed low to high)
  localparam int MEMWB_ADDRLO_LO  = 0;
  localparam int MEMWB_LDSIGNED   = 2;
  localparam int MEMWB_LDSIZE_LO  = 3;
  localparam int MEMWB_PC_LO      = 5;
  localparam int MEMWB_MEMDATA_LO = 37;
  localparam int MEMWB_ALURES_LO  = 69;
  localparam int MEMWB_WBSEL_LO   = 101;
  localparam int MEMWB_RDS_LO     = 103;
  localparam int MEMWB_REGWRITE   = 108;
  localparam int MEMWB_VALID      = 109;
  localparam int MEMWB_WIDTH      = 110;

  // Only the valid bit is cleared by a flush; payload bits are left alone
  localparam logic [MEMWB_WIDTH-1:0] MEMWB_FLUSH_MASK =
    MEMWB_WIDTH'(1) << MEMWB_VALID;

  // Link address of an instruction; wraps naturally at 2^32
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pipereg.sv
// Generic pipeline register with enable, masked clear and active-high
// asynchronous reset. Clear has priority over the enable.
module pipereg #(
  parameter int               WIDTH    = 1,
  parameter logic [WIDTH-1:0] CLR_MASK = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // Capture on enable, drop masked bits on clear, zero everything on reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (clr_i) begin
      data_q <= data_q & ~CLR_MASK;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/wb_load_align.sv
// Little-endian load lane selection with zero or sign extension.
// Half accesses use lane addr[1]; byte accesses use lane addr[1:0].
module wb_load_align
  import pipelinedefs::*;
(
  input  logic [31:0] mem_data_i,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_signed_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] data_o
);

  logic [15:0] halfLane;
  logic [7:0]  byteLane;

  // Pick the addressed half-word and byte out of the raw memory word
  always_comb begin
    halfLane = addr_lo_i[1] ? mem_data_i[31:16] : mem_data_i[15:0];
    byteLane = mem_data_i[8*addr_lo_i +: 8];
  end

  // Extend the selected lane according to size and signedness
  always_comb begin
    data_o = mem_data_i;
    case (ldsize_e'(ld_size_i))
      LD_WORD:           data_o = mem_data_i;
      LD_HALF:           data_o = {{16{ld_signed_i & halfLane[15]}}, halfLane};
      LD_BYTE, LD_BYTE2: data_o = {{24{ld_signed_i & byteLane[7]}}, byteLane};
      default:           data_o = mem_data_i;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: MEM/WB pipeline register, result selection, register
// file write port and retired-instruction counter.
// Optional macro WB_BYPASS_EN adds a registered copy of the previous
// cycle's write port for decode-stage bypassing.
module writeback_stage
  import pipelinedefs::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                Clk,
  input  logic                reset,
  input  logic                iValid,
  input  logic                iRegWrite,
  input  logic [4:0]          iRDS,
  input  logic [1:0]          iWbSel,
  input  logic [31:0]         iALURes,
  input  logic [31:0]         iMemData,
  input  logic [31:0]         iPC,
  input  logic [1:0]          iLdSize,
  input  logic                iLdSigned,
  input  logic [1:0]          iAddrLo,
  input  logic                stall,
  input  logic                flush,
  output logic                rf_we,
  output logic [4:0]          WAddr,
  output logic [31:0]         WData,
  output logic [RETIRE_W-1:0] oRetired
`ifdef WB_BYPASS_EN
  ,
  output logic                oFwdValid,
  output logic [4:0]          oFwdAddr,
  output logic [31:0]         oFwdData
`endif
);

  logic                   rstHigh;
  logic [MEMWB_WIDTH-1:0] memwb_d;
  logic [MEMWB_WIDTH-1:0] memwb_q;

  logic        wbValid;
  logic        wbRegWrite;
  logic [4:0]  wbRds;
  logic [1:0]  wbSel;
  logic [31:0] aluRes;
  logic [31:0] memData;
  logic [31:0] pcVal;
  logic [1:0]  ldSize;
  logic        ldSigned;
  logic [1:0]  addrLo;
  logic [31:0] loadData;
  logic [31:0] wbData;
  logic        rfWe;

  logic [RETIRE_W-1:0] retired_d;
  logic [RETIRE_W-1:0] retired_q;

  assign rstHigh = ~reset;

  assign memwb_d = {iValid, iRegWrite, iRDS, iWbSel, iALURes, iMemData,
                    iPC, iLdSize, iLdSigned, iAddrLo};

  pipereg #(
    .WIDTH    (MEMWB_WIDTH),
    .CLR_MASK (MEMWB_FLUSH_MASK)
  ) u_memwb (
    .clk_i (Clk),
    .rst_i (rstHigh),
    .en_i  (~stall),
    .clr_i (flush),
    .d_i   (memwb_d),
    .q_o   (memwb_q)
  );

  assign wbValid    = memwb_q[MEMWB_VALID];
  assign wbRegWrite = memwb_q[MEMWB_REGWRITE];
  assign wbRds      = memwb_q[MEMWB_RDS_LO +: 5];
  assign wbSel      = memwb_q[MEMWB_WBSEL_LO +: 2];
  assign aluRes     = memwb_q[MEMWB_ALURES_LO +: 32];
  assign memData    = memwb_q[MEMWB_MEMDATA_LO +: 32];
  assign pcVal      = memwb_q[MEMWB_PC_LO +: 32];
  assign ldSize     = memwb_q[MEMWB_LDSIZE_LO +: 2];
  assign ldSigned   = memwb_q[MEMWB_LDSIGNED];
  assign addrLo     = memwb_q[MEMWB_ADDRLO_LO +: 2];

  wb_load_align u_align (
    .mem_data_i  (memData),
    .ld_size_i   (ldSize),
    .ld_signed_i (ldSigned),
    .addr_lo_i   (addrLo),
    .data_o      (loadData)
  );

  // Choose the writeback value from the registered instruction fields
  always_comb begin
    wbData = aluRes;
    case (wbsel_e'(wbSel))
      WB_SEL_ALU, WB_SEL_ALU2: wbData = aluRes;
      WB_SEL_LOAD:             wbData = loadData;
      WB_SEL_PC4:              wbData = pc_plus4(pcVal);
      default:                 wbData = aluRes;
    endcase
  end

  // Writes to r0 are dropped here so the register file needs no special case
  assign rfWe  = wbValid & wbRegWrite & (wbRds != 5'd0);
  assign rf_we = rfWe;
  assign WAddr = wbRds;
  assign WData = wbData;

  // A held instruction retires only on the edge where the stall releases
  always_comb begin
    retired_d = retired_q;
    if (wbValid && !stall) begin
      retired_d = retired_q + RETIRE_W'(1);
    end
  end

  // Retired-instruction counter, wraps silently
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign oRetired = retired_q;

`ifdef WB_BYPASS_EN
  logic        fwdValid_q;
  logic [4:0]  fwdAddr_q;
  logic [31:0] fwdData_q;

  // Delay the write port by one cycle for same-cycle decode bypass
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      fwdValid_q <= 1'b0;
      fwdAddr_q  <= '0;
      fwdData_q  <= '0;
    end else begin
      fwdValid_q <= rfWe;
      fwdAddr_q  <= wbRds;
      fwdData_q  <= wbData;
    end
  end

  assign oFwdValid = fwdValid_q;
  assign oFwdAddr  = fwdAddr_q;
  assign oFwdData  = fwdData_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard testbench for writeback_stage: a driver pushes the expected
// post-edge outputs from a behavioural model, a monitor pops and compares.
module tb_writeback_stage;

  localparam int RW = 8;

  logic          Clk = 1'b0;
  logic          reset;
  logic          iValid;
  logic          iRegWrite;
  logic [4:0]    iRDS;
  logic [1:0]    iWbSel;
  logic [31:0]   iALURes;
  logic [31:0]   iMemData;
  logic [31:0]   iPC;
  logic [1:0]    iLdSize;
  logic          iLdSigned;
  logic [1:0]    iAddrLo;
  logic          stall;
  logic          flush;
  logic          rf_we;
  logic [4:0]    WAddr;
  logic [31:0]   WData;
  logic [RW-1:0] oRetired;
`ifdef WB_BYPASS_EN
  logic          oFwdValid;
  logic [4:0]    oFwdAddr;
  logic [31:0]   oFwdData;
`endif

  typedef struct {
    bit        valid;
    bit        regWrite;
    bit [4:0]  rd;
    bit [1:0]  wbSel;
    bit [31:0] alu;
    bit [31:0] mem;
    bit [31:0] pc;
    bit [1:0]  ldSize;
    bit        ldSigned;
    bit [1:0]  addrLo;
  } instr_t;

  typedef struct {
    bit        we;
    bit [4:0]  addr;
    bit [31:0] data;
    bit [7:0]  retired;
    bit        fwdWe;
    bit [4:0]  fwdAddr;
    bit [31:0] fwdData;
  } exp_t;

  exp_t     expQ[$];
  instr_t   held;
  bit [7:0] retiredModel;
  exp_t     lastOut;
  int       checks = 0;
  int       errors = 0;

  writeback_stage #(.RETIRE_W(RW)) dut (
    .Clk       (Clk),
    .reset     (reset),
    .iValid    (iValid),
    .iRegWrite (iRegWrite),
    .iRDS      (iRDS),
    .iWbSel    (iWbSel),
    .iALURes   (iALURes),
    .iMemData  (iMemData),
    .iPC       (iPC),
    .iLdSize   (iLdSize),
    .iLdSigned (iLdSigned),
    .iAddrLo   (iAddrLo),
    .stall     (stall),
    .flush     (flush),
    .rf_we     (rf_we),
    .WAddr     (WAddr),
    .WData     (WData),
    .oRetired  (oRetired)
`ifdef WB_BYPASS_EN
    ,
    .oFwdValid (oFwdValid),
    .oFwdAddr  (oFwdAddr),
    .oFwdData  (oFwdData)
`endif
  );

  always #5 Clk = ~Clk;

  // Safety net in case the clock or the bench stalls
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input bit expWe, input bit [4:0] expAddr,
                             input bit [31:0] expData, input bit [7:0] expRet);
    checkVal({name, ".rf_we"},    32'(rf_we),    32'(expWe));
    checkVal({name, ".WAddr"},    32'(WAddr),    32'(expAddr));
    checkVal({name, ".WData"},    WData,         expData);
    checkVal({name, ".oRetired"}, 32'(oRetired), 32'(expRet));
  endtask

  // Loaded value from byte offsets and masks rather than lane muxing
  function automatic bit [31:0] expectResult(input instr_t x);
    int unsigned nBytes;
    int unsigned offset;
    bit [63:0]   v;
    if (x.wbSel == 2'd2) return x.pc + 32'd4;
    if (x.wbSel != 2'd1) return x.alu;
    if (x.ldSize == 2'd0) return x.mem;
    nBytes = (x.ldSize == 2'd1) ? 2 : 1;
    offset = (nBytes == 2) ? (int'(x.addrLo) / 2) * 2 : int'(x.addrLo);
    v = 64'(x.mem >> (8 * offset)) & ((64'd1 << (8 * nBytes)) - 64'd1);
    if (x.ldSigned && v >= (64'd1 << (8 * nBytes - 1))) v = v - (64'd1 << (8 * nBytes));
    return v[31:0];
  endfunction

  task automatic modelReset();
    held         = '{default: 0};
    retiredModel = 8'd0;
    lastOut      = '{default: 0};
  endtask

  // One rising edge of the reference model; queues the outputs seen after it
  task automatic modelEdge(input instr_t in, input bit st, input bit fl);
    exp_t e;
    e.fwdWe   = lastOut.we;
    e.fwdAddr = lastOut.addr;
    e.fwdData = lastOut.data;
    if (held.valid && !st) retiredModel = retiredModel + 8'd1;
    if (fl) held.valid = 1'b0;
    else if (!st) held = in;
    e.we      = held.valid && held.regWrite && (held.rd != 5'd0);
    e.addr    = held.rd;
    e.data    = expectResult(held);
    e.retired = retiredModel;
    lastOut   = e;
    expQ.push_back(e);
  endtask

  task automatic driveInputs(input instr_t in, input bit st, input bit fl);
    iValid    = in.valid;
    iRegWrite = in.regWrite;
    iRDS      = in.rd;
    iWbSel    = in.wbSel;
    iALURes   = in.alu;
    iMemData  = in.mem;
    iPC       = in.pc;
    iLdSize   = in.ldSize;
    iLdSigned = in.ldSigned;
    iAddrLo   = in.addrLo;
    stall     = st;
    flush     = fl;
  endtask

  // Drive one cycle, record the expectation, land 2 time units past the edge
  task automatic applyStimulus(input instr_t in, input bit st, input bit fl);
    driveInputs(in, st, fl);
    modelEdge(in, st, fl);
    @(posedge Clk);
    #2;
  endtask

  // Monitor: compare every presented output against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkVal("sb.rf_we",    32'(rf_we),    32'(e.we));
        checkVal("sb.WAddr",    32'(WAddr),    32'(e.addr));
        checkVal("sb.WData",    WData,         e.data);
        checkVal("sb.oRetired", 32'(oRetired), 32'(e.retired));
`ifdef WB_BYPASS_EN
        checkVal("sb.oFwdValid", 32'(oFwdValid), 32'(e.fwdWe));
        checkVal("sb.oFwdAddr",  32'(oFwdAddr),  32'(e.fwdAddr));
        checkVal("sb.oFwdData",  oFwdData,       e.fwdData);
`endif
      end
    end
  end

  // Directed scenarios, a mid-run reset, then a randomized run
  initial begin
    instr_t in;
    instr_t bubble;
    bit     st;
    bit     fl;

    bubble = '{default: 0};
    reset  = 1'b0;
    driveInputs(bubble, 1'b0, 1'b0);
    modelReset();
    #3;
    checkOutput("reset", 1'b0, 5'd0, 32'd0, 8'd0);
    @(posedge Clk);
    #3;
    reset = 1'b1;

    in = '{default: 0};
    in.valid = 1; in.regWrite = 1; in.rd = 5'd5; in.wbSel = 2'b00; in.alu = 32'h12345678;
    applyStimulus(in, 1'b0, 1'b0);
    checkOutput("alu_wb", 1'b1, 5'd5, 32'h12345678, 8'd0);
    applyStimulus(bubble, 1'b0, 1'b0);
    checkOutput("alu_retire", 1'b0, 5'd0, 32'd0, 8'd1);

    in = '{default: 0};
    in.valid = 1; in.regWrite = 1; in.rd = 5'd7; in.wbSel = 2'b01;
    in.mem = 32'h80FF7F01; in.ldSize = 2'b10; in.ldSigned = 1; in.addrLo = 2'd3;
    applyStimulus(in, 1'b0, 1'b0);
    checkOutput("ldb_signed", 1'b1, 5'd7, 32'hFFFFFF80, 8'd1);
    in.addrLo = 2'd1; in.ldSigned = 0;
    applyStimulus(in, 1'b0, 1'b0);
    checkOutput("ldb_unsigned", 1'b1, 5'd7, 32'h0000007F, 8'd2);

    in = '{default: 0};
    in.valid = 1; in.regWrite = 1; in.rd = 5'd0; in.alu = 32'hDEADBEEF;
    applyStimulus(in, 1'b0, 1'b0);
    checkOutput("r0_write", 1'b0, 5'd0, 32'hDEADBEEF, 8'd3);

    in = '{default: 0};
    in.valid = 1; in.regWrite = 1; in.rd = 5'd31; in.wbSel = 2'b10; in.pc = 32'hFFFFFFFC;
    applyStimulus(in, 1'b0, 1'b0);
    checkOutput("pc4_wrap", 1'b1, 5'd31, 32'h00000000, 8'd4);

    in = '{default: 0};
    in.valid = 1; in.regWrite = 1; in.rd = 5'd3; in.alu = 32'h0BADF00D;
    applyStimulus(in, 1'b1, 1'b0);
    checkOutput("stall_hold", 1'b1, 5'd31, 32'h00000000, 8'd4);
    applyStimulus(in, 1'b1, 1'b1);
    checkOutput("stall_flush", 1'b0, 5'd31, 32'h00000000, 8'd4);

    in = '{default: 0};
    in.valid = 1; in.regWrite = 1; in.rd = 5'd9; in.alu = 32'h00000055;
    applyStimulus(in, 1'b0, 1'b0);
    checkOutput("pre_reset", 1'b1, 5'd9, 32'h00000055, 8'd4);

    #1;
    reset = 1'b0;
    #1;
    checkOutput("mid_reset", 1'b0, 5'd0, 32'd0, 8'd0);
    in.rd = 5'd12; in.alu = 32'hCAFEF00D;
    driveInputs(in, 1'b0, 1'b0);
    @(posedge Clk);
    #3;
    reset = 1'b1;
    modelReset();
    applyStimulus(bubble, 1'b0, 1'b0);
    checkOutput("post_reset", 1'b0, 5'd0, 32'd0, 8'd0);

    for (int i = 0; i < 700; i++) begin
      in.valid    = ($urandom_range(0, 3) != 0);
      in.regWrite = ($urandom_range(0, 3) != 0);
      in.rd       = 5'($urandom);
      in.wbSel    = 2'($urandom);
      in.alu      = $urandom;
      in.mem      = $urandom;
      in.pc       = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
      in.ldSize   = 2'($urandom);
      in.ldSigned = 1'($urandom);
      in.addrLo   = 2'($urandom);
      st          = ($urandom_range(0, 3) == 0);
      fl          = ($urandom_range(0, 7) == 0);
      applyStimulus(in, st, fl);
    end

    driveInputs(bubble, 1'b1, 1'b0);
    repeat (2) @(posedge Clk);
    #2;
    checkVal("drain.queue", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter RETIRE_W, default 32, meaning retired-instruction counter width (legal 8..64).
REQ-002 SHALL have port Clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port iValid, input, 1, MEM-stage instruction valid.
REQ-005 SHALL have port iRegWrite, input, 1, instruction writes a destination register.
REQ-006 SHALL have port iRDS, input, 5, destination register address.
REQ-007 SHALL have port iWbSel, input, 2, result source: 00 ALU, 01 load, 10 PC+4, 11 ALU.
REQ-008 SHALL have ports iALURes, iMemData and iPC, input, 32 each, ALU result, raw memory word and instruction PC.
REQ-009 SHALL have ports iLdSize (input, 2: 00 word, 01 half, 10/11 byte), iLdSigned (input, 1) and iAddrLo (input, 2, load address bits [1:0]).
REQ-010 SHALL have ports stall and flush, input, 1 each, hazard control for the MEM/WB register.
REQ-011 SHALL have outputs rf_we (1), WAddr (5) and WData (32), the register-file write port driven toward DecodeStage.
REQ-012 SHALL have output oRetired, RETIRE_W, count of retired valid instructions.

Function
REQ-013 SHALL capture all MEM-side inputs into a MEM/WB pipeline register on each rising edge when stall=0 and flush=0.
REQ-014 SHALL hold the register contents when stall=1 and flush=0.
REQ-015 SHALL clear only the registered valid bit when flush=1, regardless of stall (flush wins).
REQ-016 SHALL drive rf_we = registered valid AND registered RegWrite AND registered RDS != 0 (writes to r0 suppressed).
REQ-017 SHALL drive WAddr = registered RDS and WData from registered fields combinationally, giving a one-cycle latency from MEM input capture to write-port presentation.
REQ-018 SHALL select load bytes little-endian: half uses lane iAddrLo[1] (iAddrLo[0] ignored), byte uses lane iAddrLo; word ignores iAddrLo.
REQ-019 SHALL zero-extend sub-word loads when iLdSigned=0 and sign-extend from the lane MSB when iLdSigned=1.
REQ-020 SHALL produce WData = PC+4 modulo 2^32 for iWbSel=10, with wrap from 0xFFFFFFFC to 0x00000000.
REQ-021 SHALL increment oRetired by one on each rising edge where registered valid=1 and stall=0; a held stalled instruction counts once, and a flushed bubble counts zero.
REQ-022 SHALL wrap oRetired from all-ones to zero without flag.
REQ-023 SHALL keep rf_we asserted for the full stall duration when a valid writing instruction is held.

Reset
REQ-024 SHALL, while reset=0, asynchronously clear registered valid, RegWrite and RDS, all data fields and oRetired to zero, forcing rf_we=0, WAddr=0 and WData=0.
REQ-025 SHALL resume capture on the first rising edge after reset deasserts; an instruction in flight at reset assertion is discarded and not counted.

Configuration
REQ-026 SHALL, with macro WB_BYPASS_EN defined, add outputs oFwdValid (1), oFwdAddr (5) and oFwdData (32) holding a registered copy of the previous cycle's rf_we/WAddr/WData, reset to zero, for same-cycle write/read bypass in decode.
REQ-027 SHALL, with WB_BYPASS_EN undefined, omit those ports and their registers entirely.

Structure
REQ-028 SHALL place the MEMWB_* field-range macros, MEMWB_WIDTH, WbSel encodings and LdSize encodings in the shared pipelinedefs package.
REQ-029 SHALL implement load lane selection and extension in one combinational sub-module, wb_load_align.
REQ-030 SHALL reuse the shared pipereg block for the MEM/WB register, fed with an active-high reset derived from reset.

Verification
REQ-031 SHALL test ALU writeback: iValid=1, iRegWrite=1, iRDS=5, iWbSel=00, iALURes=0x12345678 -> next cycle rf_we=1, WAddr=5, WData=0x12345678, oRetired=1 after the following edge.
REQ-032 SHALL test signed byte load: iMemData=0x80FF7F01, iLdSize=10, iLdSigned=1, iAddrLo=3 -> WData=0xFFFFFF80; with iAddrLo=1 and iLdSigned=0 -> WData=0x0000007F.
REQ-033 SHALL test r0 suppression: iRDS=0, iRegWrite=1, iValid=1 -> rf_we=0, oRetired still increments.
REQ-034 SHALL test simultaneous stall=1 and flush=1 with valid instruction held -> next cycle rf_we=0 and oRetired unchanged.
REQ-035 SHALL test PC+4 wrap: iPC=0xFFFFFFFC, iWbSel=10, iRDS=31 -> WData=0x00000000, WAddr=31.
REQ-036 SHALL test mid-operation reset: assert reset=0 between edges while rf_we=1 -> rf_we drops to 0 immediately, oRetired reads 0.
